// File: rtl/tanh_layer_seq.sv
// Lane-serial tanh layer: 3-segment piecewise-linear forward with an internal y cache,
// and backward dx = dy*(1-y^2) computed from that cache, LANES elements per cycle.
module tanh_layer_seq #(
  parameter int unsigned N_ELEM  = 64,
  parameter int unsigned LANES   = 4,
  parameter int unsigned N_LEN   = 16,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned N_LEN_W = 8,
  parameter int unsigned FRAC_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run_forward,
  input  logic                      run_backward,
  input  logic [N_ELEM*N_LEN-1:0]   d_forward,
  input  logic [N_ELEM*N_LEN-1:0]   d_backward,
  output logic                      busy,
  output logic                      valid_forward,
  output logic                      valid_backward,
  output logic [N_ELEM*N_LEN_W-1:0] q_forward,
  output logic [N_ELEM*N_LEN-1:0]   q_backward
);

  localparam int unsigned STEPS   = N_ELEM / LANES;
  localparam int unsigned STEP_W  = $clog2(STEPS + 1);
  localparam int unsigned A_W     = N_LEN + 1;
  localparam int unsigned P_W     = 2 * N_LEN_W + 2;
  localparam int unsigned PR_W    = N_LEN + P_W;
  localparam int unsigned SHIFT_F = FRAC - FRAC_W;
  localparam int unsigned SHIFT_B = 2 * FRAC_W;

  localparam logic [A_W-1:0]        A_MAX     = {2'b00, {(N_LEN-1){1'b1}}};
  localparam logic [A_W-1:0]        A_HALF    = A_W'(1) << (FRAC - 1);
  localparam logic [A_W-1:0]        A_KNEE    = A_W'(5) << (FRAC - 1);
  localparam logic [A_W-1:0]        M_OFS     = A_W'(3) << (FRAC - 3);
  localparam logic [A_W-1:0]        M_ONE     = A_W'(1) << FRAC;
  localparam logic signed [P_W-1:0] G_ONE     = P_W'(1) << SHIFT_B;
  localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(STEPS);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_BWD, S_DONE_F, S_DONE_B} state_t;

  // Magnitude is computed on |x| so the result is exactly odd-symmetric.
  function automatic logic [N_LEN_W-1:0] fwd_elem(input logic [N_LEN-1:0] x);
    logic [A_W-1:0] a;
    logic [A_W-1:0] m;
    logic [A_W-1:0] mw;
    a = x[N_LEN-1] ? A_W'(0) - {x[N_LEN-1], x} : {1'b0, x};
    if (a > A_MAX) a = A_MAX;
    if (a < A_HALF)      m = a;
    else if (a < A_KNEE) m = (a >> 2) + M_OFS;
    else                 m = M_ONE;
    mw = m >> SHIFT_F;
    return x[N_LEN-1] ? N_LEN_W'(A_W'(0) - mw) : N_LEN_W'(mw);
  endfunction

  function automatic logic [N_LEN-1:0] bwd_elem(input logic [N_LEN-1:0] dy,
                                                input logic [N_LEN_W-1:0] y);
    logic signed [P_W-1:0]  ys;
    logic signed [P_W-1:0]  g;
    logic signed [PR_W-1:0] dys;
    logic signed [PR_W-1:0] gs;
    logic signed [PR_W-1:0] pr;
    ys  = $signed({{(P_W-N_LEN_W){y[N_LEN_W-1]}}, y});
    g   = G_ONE - ys * ys;
    dys = $signed({{(PR_W-N_LEN){dy[N_LEN-1]}}, dy});
    gs  = $signed({{(PR_W-P_W){g[P_W-1]}}, g});
    pr  = dys * gs;
    return N_LEN'(pr >>> SHIFT_B);
  endfunction

  state_t                   state_q, state_d;
  logic [STEP_W-1:0]        step_q, step_d, step_c, wr_step_q;
  logic [N_ELEM*N_LEN-1:0]  data_q;
  logic [LANES*N_LEN-1:0]   stage_q, stage_d;
  logic                     stage_vld_q, stage_vld_d;
  logic [N_ELEM*N_LEN_W-1:0] y_q;
  logic [N_ELEM*N_LEN-1:0]  dx_q;
  logic                     busy_q, vf_q, vb_q;

  // Next-state: one extra step after the last lane drains the stage register.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (run_forward)       state_d = S_FWD;
        else if (run_backward) state_d = S_BWD;
      end
      S_FWD, S_BWD: begin
        if (step_q == LAST_STEP) state_d = (state_q == S_FWD) ? S_DONE_F : S_DONE_B;
        else                     step_d  = step_q + STEP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane datapath for the current step.
  always_comb begin
    stage_d     = '0;
    stage_vld_d = (state_q == S_FWD || state_q == S_BWD) && (step_q != LAST_STEP);
    step_c      = (step_q == LAST_STEP) ? '0 : step_q;
    for (int l = 0; l < LANES; l++) begin
      if (state_q == S_BWD)
        stage_d[l*N_LEN +: N_LEN] =
          bwd_elem(data_q[(int'(step_c)*LANES + l)*N_LEN +: N_LEN],
                   y_q[(int'(step_c)*LANES + l)*N_LEN_W +: N_LEN_W]);
      else
        stage_d[l*N_LEN +: N_LEN] =
          N_LEN'(fwd_elem(data_q[(int'(step_c)*LANES + l)*N_LEN +: N_LEN]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      wr_step_q   <= '0;
      data_q      <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      y_q         <= '0;
      dx_q        <= '0;
      busy_q      <= 1'b0;
      vf_q        <= 1'b0;
      vb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wr_step_q   <= step_c;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      busy_q      <= (state_d != S_IDLE);
      vf_q        <= (state_d == S_DONE_F);
      vb_q        <= (state_d == S_DONE_B);
      if (state_q == S_IDLE && state_d != S_IDLE)
        data_q <= run_forward ? d_forward : d_backward;
      if (stage_vld_q) begin
        for (int l = 0; l < LANES; l++) begin
          if (state_q == S_FWD)
            y_q[(int'(wr_step_q)*LANES + l)*N_LEN_W +: N_LEN_W] <= stage_q[l*N_LEN +: N_LEN_W];
          else
            dx_q[(int'(wr_step_q)*LANES + l)*N_LEN +: N_LEN] <= stage_q[l*N_LEN +: N_LEN];
        end
      end
    end
  end

  assign busy           = busy_q;
  assign valid_forward  = vf_q;
  assign valid_backward = vb_q;
  assign q_forward      = y_q;
  assign q_backward     = dx_q;

endmodule

// File: tb/tb_tanh_layer_seq.sv
// Randomized bench for tanh_layer_seq against an integer-arithmetic model of the layer.
`timescale 1ns/1ps
module tb_tanh_layer_seq;
  localparam int N_ELEM  = 64;
  localparam int LANES   = 4;
  localparam int N_LEN   = 16;
  localparam int FRAC    = 8;
  localparam int N_LEN_W = 8;
  localparam int FRAC_W  = 6;
  localparam int WX      = N_ELEM * N_LEN;
  localparam int WY      = N_ELEM * N_LEN_W;
  localparam int CW      = 512;
  localparam int LAT     = N_ELEM / LANES + 2;

  logic clk = 1'b0, rst = 1'b1, run_forward = 1'b0, run_backward = 1'b0;
  logic [WX-1:0] d_forward = '0, d_backward = '0;
  logic busy, valid_forward, valid_backward;
  logic [WY-1:0] q_forward;
  logic [WX-1:0] q_backward;

  int checks = 0, failures = 0;
  int ycache[N_ELEM];
  int dxm[N_ELEM];

  always #5 clk = ~clk;

  tanh_layer_seq #(.N_ELEM(N_ELEM), .LANES(LANES), .N_LEN(N_LEN), .FRAC(FRAC),
                   .N_LEN_W(N_LEN_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .run_forward(run_forward), .run_backward(run_backward),
    .d_forward(d_forward), .d_backward(d_backward), .busy(busy),
    .valid_forward(valid_forward), .valid_backward(valid_backward),
    .q_forward(q_forward), .q_backward(q_backward));

  task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tanh_ref(input int x);
    int a, m;
    a = (x < 0) ? -x : x;
    if (a > (1 << (N_LEN-1)) - 1) a = (1 << (N_LEN-1)) - 1;
    if (a < (1 << FRAC) / 2)          m = a;
    else if (a < 5 * (1 << FRAC) / 2) m = a / 4 + 3 * (1 << FRAC) / 8;
    else                              m = 1 << FRAC;
    m = m / (1 << (FRAC - FRAC_W));
    return (x < 0) ? -m : m;
  endfunction

  function automatic int dx_ref(input int dy, input int y);
    int g;
    g = (1 << (2*FRAC_W)) - y * y;
    return (dy * g) >>> (2*FRAC_W);
  endfunction

  // Biased toward small magnitudes so all three segments get exercised.
  function automatic logic [WX-1:0] rand_vec();
    logic [WX-1:0] v;
    logic [31:0] r;
    for (int i = 0; i < N_ELEM; i++) begin
      r = $urandom;
      v[i*N_LEN +: N_LEN] = r[31] ? {{5{r[10]}}, r[10:0]} : r[15:0];
    end
    return v;
  endfunction

  function automatic logic [WX-1:0] fill16(input logic [15:0] e);
    logic [WX-1:0] v;
    for (int i = 0; i < N_ELEM; i++) v[i*N_LEN +: N_LEN] = e;
    return v;
  endfunction

  function automatic logic [WY-1:0] fill8(input logic [7:0] e);
    logic [WY-1:0] v;
    for (int i = 0; i < N_ELEM; i++) v[i*N_LEN_W +: N_LEN_W] = e;
    return v;
  endfunction

  task automatic check_q(input string tag, input logic [WY-1:0] ef, input logic [WX-1:0] eb);
    check_val({tag, "_qf"}, q_forward, ef);
    check_val({tag, "_qb_lo"}, q_backward[CW-1:0], eb[CW-1:0]);
    check_val({tag, "_qb_hi"}, q_backward[WX-1:CW], eb[WX-1:CW]);
  endtask

  task automatic run_op(input string tag, input bit fwd, input bit bwd,
                        input logic [WX-1:0] vec, input bit inj);
    logic [WY-1:0] expf;
    logic [WX-1:0] expb;
    int cyc, busy_low, wrong_v;
    bit exp_f;
    exp_f = fwd;
    for (int i = 0; i < N_ELEM; i++) begin
      if (exp_f) ycache[i] = tanh_ref(int'($signed(vec[i*N_LEN +: N_LEN])));
      else       dxm[i]    = dx_ref(int'($signed(vec[i*N_LEN +: N_LEN])), ycache[i]);
    end
    for (int i = 0; i < N_ELEM; i++) begin
      expf[i*N_LEN_W +: N_LEN_W] = N_LEN_W'(ycache[i]);
      expb[i*N_LEN +: N_LEN]     = N_LEN'(dxm[i]);
    end
    @(negedge clk);
    run_forward  = fwd;
    run_backward = bwd;
    d_forward    = fwd ? vec : rand_vec();
    d_backward   = (bwd && !fwd) ? vec : rand_vec();
    @(posedge clk); #1;
    run_forward  = 1'b0;
    run_backward = 1'b0;
    d_forward    = rand_vec();
    d_backward   = rand_vec();
    cyc = 1; busy_low = 0; wrong_v = 0;
    while (!(exp_f ? valid_forward : valid_backward) && cyc < 4 * LAT) begin
      if (busy !== 1'b1) busy_low++;
      if ((exp_f ? valid_backward : valid_forward) !== 1'b0) wrong_v++;
      if (inj && cyc == 5) begin run_forward = 1'b1; run_backward = 1'b1; end
      if (inj && cyc == 6) begin run_forward = 1'b0; run_backward = 1'b0; end
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_lat"}, CW'(cyc), CW'(LAT));
    check_val({tag, "_busy_run"}, CW'(busy_low), CW'(0));
    check_val({tag, "_other_valid"},
              CW'(wrong_v) + CW'(exp_f ? valid_backward : valid_forward), CW'(0));
    check_val({tag, "_busy_done"}, CW'(busy), CW'(1));
    check_q(tag, expf, expb);
    if (inj) begin run_forward = 1'b1; run_backward = 1'b1; end
    @(posedge clk); #1;
    run_forward  = 1'b0;
    run_backward = 1'b0;
    check_val({tag, "_idle"}, CW'({busy, valid_forward, valid_backward}), CW'(0));
    check_q({tag, "_hold"}, expf, expb);
    if (inj) begin
      @(posedge clk); #1;
      check_val({tag, "_ignored"}, CW'({busy, valid_forward, valid_backward}), CW'(0));
    end
  endtask

  initial begin
    logic [WX-1:0] cvec;
    logic [WY-1:0] cexp;
    int sx[4];
    int sy[4];
    int nv;
    sx = '{'h0400, 'hFC00, 'h8000, 'hFF00};
    sy = '{'h40, 'hC0, 'hC0, 'hD8};
    for (int i = 0; i < N_ELEM; i++) begin ycache[i] = 0; dxm[i] = 0; end

    repeat (3) @(posedge clk);
    #1;
    check_q("reset", '0, '0);
    check_val("reset_ctl", CW'({busy, valid_forward, valid_backward}), CW'(0));
    @(negedge clk) rst = 1'b0;

    run_op("bwd_empty", 1'b0, 1'b1, fill16(16'hFF37), 1'b0);
    cvec = fill16(16'hFF37);
    check_val("bwd_empty_const", q_backward[CW-1:0], cvec[CW-1:0]);

    run_op("fwd_q25", 1'b1, 1'b0, fill16(16'h0040), 1'b0);
    check_val("fwd_q25_const", q_forward, fill8(8'h10));
    run_op("fwd_one", 1'b1, 1'b0, fill16(16'h0100), 1'b0);
    check_val("fwd_one_const", q_forward, fill8(8'h28));
    run_op("bwd_one", 1'b0, 1'b1, fill16(16'h0100), 1'b0);
    cvec = fill16(16'h009C);
    check_val("bwd_one_const_lo", q_backward[CW-1:0], cvec[CW-1:0]);
    check_val("bwd_one_const_hi", q_backward[WX-1:CW], cvec[WX-1:CW]);

    for (int i = 0; i < N_ELEM; i++) begin
      cvec[i*N_LEN +: N_LEN]     = N_LEN'(sx[i % 4]);
      cexp[i*N_LEN_W +: N_LEN_W] = N_LEN_W'(sy[i % 4]);
    end
    run_op("fwd_special", 1'b1, 1'b0, cvec, 1'b0);
    check_val("fwd_special_const", q_forward, cexp);

    run_op("both", 1'b1, 1'b1, rand_vec(), 1'b1);
    run_op("bwd_busy", 1'b0, 1'b1, rand_vec(), 1'b1);

    for (int r = 0; r < 5; r++) begin
      run_op("rnd_fwd", 1'b1, 1'b0, rand_vec(), 1'b0);
      run_op("rnd_bwd", 1'b0, 1'b1, rand_vec(), 1'b0);
      run_op("rnd_bwd2", 1'b0, 1'b1, rand_vec(), 1'b0);
    end

    // Abort a forward run with an asynchronous reset.
    @(negedge clk);
    run_forward = 1'b1;
    d_forward   = rand_vec();
    @(posedge clk); #1;
    run_forward = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N_ELEM; i++) begin ycache[i] = 0; dxm[i] = 0; end
    check_q("rst_mid", '0, '0);
    check_val("rst_mid_ctl", CW'({busy, valid_forward, valid_backward}), CW'(0));
    @(negedge clk) rst = 1'b0;
    nv = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      nv += int'(valid_forward) + int'(valid_backward) + int'(busy);
    end
    check_val("rst_no_valid", CW'(nv), CW'(0));
    run_op("bwd_after_rst", 1'b0, 1'b1, fill16(16'hFF37), 1'b0);
    run_op("fwd_after_rst", 1'b1, 1'b0, rand_vec(), 1'b0);
    run_op("bwd_final", 1'b0, 1'b1, rand_vec(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
